tt_um_digi_ota: RTL and testbench
=================================

Name: tt_um_digi_ota

Overview:
- Digital behavioural model of an operational transconductance amplifier (OTA) for a Tiny Tapeout user slot.
- Two 8-bit unsigned inputs, Vp and Vn, drive a tail-current-limited transconductance stage.
- That stage charges a leaky 16-bit output node that models the load capacitor plus output conductance.
- The upper byte of the node is the amplifier output. The block is the top-level user module behind the standard TT harness.

Parameters:
ILIM, 64, tail-current clip magnitude applied to Vp-Vn (signed units)
GM_SHIFT, 2, transconductance gain: current = clipped_diff <<< GM_SHIFT
LEAK_SHIFT, 6, output conductance: leak = (vout - 0x8000) >>> LEAK_SHIFT
VMID, 16'h8000, reset/mid-rail value of the output node

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  reset, synchronous and active-high (port name kept from the harness convention; 1 = reset)
ena  input  1  enable; 1 = node updates, 0 = node holds
ui_in  input  8  Vp, unsigned non-inverting input
uio_in  input  8  Vn, unsigned inverting input
uo_out  output  8  Vout = vout[15:8]
uio_out  output  8  constant 8'h00
uio_oe  output  8  constant 8'h00 (all bidirectionals are inputs)

Behaviour:
- State is a single 16-bit unsigned register, vout.
- Reset: when rst_n=1 at a rising edge, vout <= VMID. uo_out therefore reads 0x80. Reset overrides ena and the inputs.
- When ena=0 and not in reset, vout holds.
- When ena=1 and not in reset, each rising edge computes, with ≥18-bit signed intermediates:
  - diff = {1'b0,ui_in} - {1'b0,uio_in}, signed, range -255..255
  - i = clamp(diff, -ILIM, +ILIM)
  - cur = i <<< GM_SHIFT
  - leak = (vout - VMID) >>> LEAK_SHIFT, arithmetic shift (floor toward -inf)
  - next = vout + cur - leak, saturated to 0..0xFFFF; then vout <= next
- uo_out = vout[15:8], taken directly from the register. Latency is 1 clock from an input change to the first vout change.
- uio_out and uio_oe are tied to 0 in all states, including reset.
- Steady state with defaults: vout - VMID converges to about cur << LEAK_SHIFT = i*256.
  - DC gain is 1: uo_out settles to 0x80 + clamp(Vp - Vn, ±64).
  - Output range is 0x40..0xC0.
  - Time constant ≈ 2^LEAK_SHIFT = 64 cycles; settling completes within 1000 cycles.
- Vp == Vn with vout == VMID: node stays exactly at VMID (leak 0, cur 0).
- Equal-magnitude positive and negative diffs give outputs symmetric about 0x80, to within 1 LSB of uo_out due to the floor shift.
- Saturation at 0 / 0xFFFF must clamp, never wrap. It is unreachable with the defaults but required for other parameter sets.

Test Plan:
- Reset: rst_n=1 for 2 cycles with ui_in=0xFF, uio_in=0x00, ena=1 → uo_out=0x80, uio_out=0x00, uio_oe=0x00. Release with ui_in=uio_in=0x55 → uo_out stays 0x80 for 200 cycles.
- Single step: from reset, ena=1, ui_in=0xE4, uio_in=0x00 (diff 228, clipped to 64) → after 1 edge vout=0x8100, uo_out=0x81. After 1000 cycles uo_out=0xC0.
- Linear region: from reset, ui_in=0x90, uio_in=0x80 → uo_out increases monotonically and equals 0x90 after 1000 cycles. Then swap the inputs → settles to 0x70.
- Negative clip: ui_in=0x00, uio_in=0xFF → settles to 0x40, never below.
- Hold: mid-transient, drop ena for 50 cycles → uo_out frozen; raise ena → settling resumes from the frozen value.
- Mid-operation reset: while settled at 0xC0, assert rst_n for 1 cycle → next cycle uo_out=0x80. With inputs unchanged, it then re-settles to 0xC0.

Source files
------------

// File: rtl/tt_um_digi_ota.sv
// tt_um_digi_ota: behavioural OTA for a Tiny Tapeout user slot.
// A tail-current-limited transconductance stage (Vp - Vn) charges a leaky
// 16-bit output node. The node's upper byte is the amplifier output.
//
// Ports:
//   clk     - system clock, all state on the rising edge
//   rst_n   - synchronous reset, ACTIVE-HIGH (1 = reset), name kept from harness
//   ena     - 1 = node integrates, 0 = node holds
//   ui_in   - Vp, unsigned non-inverting input
//   uio_in  - Vn, unsigned inverting input
//   uo_out  - Vout = vout[15:8]
//   uio_out - tied 0
//   uio_oe  - tied 0 (all bidirectionals are inputs)
module tt_um_digi_ota #(
  parameter int          ILIM       = 64,
  parameter int          GM_SHIFT   = 2,
  parameter int          LEAK_SHIFT = 6,
  parameter logic [15:0] VMID       = 16'h8000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  // Wide enough that node (17b signed) plus +/-255<<GM_SHIFT never overflows,
  // so saturation below sees the true sum rather than a wrapped one.
  localparam int W = 20 + GM_SHIFT;

  localparam logic signed [W-1:0] LIM_P = W'(ILIM);
  localparam logic signed [W-1:0] LIM_N = -LIM_P;
  localparam logic signed [W-1:0] VMAX  = W'(65535);
  localparam logic signed [W-1:0] VMID_S = W'(VMID);

  logic [15:0]         vout;
  logic [15:0]         vout_nxt;
  logic signed [W-1:0] diff, i_clip, cur, leak, sum;

  always_comb begin
    diff   = $signed(W'(ui_in)) - $signed(W'(uio_in));
    i_clip = diff;
    if (diff > LIM_P)      i_clip = LIM_P;
    else if (diff < LIM_N) i_clip = LIM_N;
    cur  = i_clip <<< GM_SHIFT;
    // Arithmetic shift floors toward -inf, so small negative offsets still leak.
    leak = ($signed(W'(vout)) - VMID_S) >>> LEAK_SHIFT;
    sum  = $signed(W'(vout)) + cur - leak;
    if (sum[W-1])         vout_nxt = 16'h0000;
    else if (sum > VMAX)  vout_nxt = 16'hFFFF;
    else                  vout_nxt = sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n)    vout <= VMID;
    else if (ena) vout <= vout_nxt;
  end

  assign uo_out  = vout[15:8];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_digi_ota.sv
// Bench for tt_um_digi_ota: directed scenarios followed by random stimulus,
// each cycle compared against an integer reference of the node equation.
// A second instance with aggressive gain exercises the 0/0xFFFF clamps.
module tb_tt_um_digi_ota;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out_s, uio_out_s, uio_oe_s;

  int checks = 0;
  int errors = 0;
  int mv, ms;            // reference node values (default / saturating instance)
  int prev, frozen;

  always #5 clk = ~clk;

  tt_um_digi_ota u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_digi_ota #(.ILIM(128), .GM_SHIFT(6), .LEAK_SHIFT(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_s), .uio_out(uio_out_s), .uio_oe(uio_oe_s)
  );

  // Reference: plain integer arithmetic with explicit floor division.
  function automatic int model_next(int v, int vp, int vn, int ilim, int gs, int ls);
    int d, i, cur, q, off, leak, n;
    d = vp - vn;
    i = (d > ilim) ? ilim : (d < -ilim) ? -ilim : d;
    cur = i * (1 << gs);
    q = 1 << ls;
    off = v - 32768;
    leak = (off >= 0) ? off / q : -((-off + q - 1) / q);
    n = v + cur - leak;
    if (n < 0) n = 0;
    if (n > 65535) n = 65535;
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond, input int obs);
    checks++;
    assert (cond) else begin
      errors++;
      $error("FAIL %s: observed %0h violates bound", tag, obs);
    end
  endtask

  // One clock: advance the reference on the edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      mv = 32768; ms = 32768;
    end else if (ena) begin
      mv = model_next(mv, int'(ui_in), int'(uio_in), 64, 2, 6);
      ms = model_next(ms, int'(ui_in), int'(uio_in), 128, 6, 10);
    end
    @(negedge clk);
    chk("uo_out", int'(uo_out), mv >> 8);
    chk("uo_out_sat", int'(uo_out_s), ms >> 8);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b1; cyc(); rst_n = 1'b0;
  endtask

  initial begin
    mv = 32768; ms = 32768;
    // Reset with inputs that would otherwise drive hard.
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h00;
    cyc(); cyc();
    chk("reset_uo", int'(uo_out), 'h80);
    chk("reset_uio_out", int'(uio_out), 0);
    chk("reset_uio_oe", int'(uio_oe), 0);
    chk("reset_uio_oe_sat", int'(uio_oe_s | uio_out_s), 0);

    // Balanced inputs at mid-rail: node must not drift.
    rst_n = 1'b0; ui_in = 8'h55; uio_in = 8'h55;
    for (int k = 0; k < 200; k++) begin
      cyc(); chk("balanced_hold", int'(uo_out), 'h80);
    end

    // Single step, clipped to ILIM.
    do_reset();
    ui_in = 8'hE4; uio_in = 8'h00;
    cyc();
    chk("step_first", int'(uo_out), 'h81);
    run(1000);
    chk("step_settled", int'(uo_out), 'hC0);
    chk("sat_high", int'(uo_out_s), 'hFF);

    // Linear region, monotonic rise then swap.
    do_reset();
    ui_in = 8'h90; uio_in = 8'h80;
    prev = int'(uo_out);
    for (int k = 0; k < 1000; k++) begin
      cyc();
      chk_true("linear_monotonic", int'(uo_out) >= prev, int'(uo_out));
      prev = int'(uo_out);
    end
    chk("linear_settled", int'(uo_out), 'h90);
    ui_in = 8'h80; uio_in = 8'h90;
    run(1000);
    chk("linear_swapped", int'(uo_out), 'h70);

    // Negative clip: floor at 0x40.
    ui_in = 8'h00; uio_in = 8'hFF;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      chk_true("neg_bound", int'(uo_out) >= 'h40, int'(uo_out));
    end
    chk("neg_settled", int'(uo_out), 'h40);
    chk("sat_low", int'(uo_out_s), 'h00);

    // Hold mid-transient.
    do_reset();
    ui_in = 8'hE4; uio_in = 8'h00;
    run(30);
    ena = 1'b0;
    frozen = int'(uo_out);
    for (int k = 0; k < 50; k++) begin
      cyc(); chk("hold_frozen", int'(uo_out), frozen);
    end
    ena = 1'b1;
    cyc();
    chk_true("hold_resume", int'(uo_out) >= frozen, int'(uo_out));
    run(1000);
    chk("hold_settled", int'(uo_out), 'hC0);

    // Reset while settled, then re-settle.
    do_reset();
    chk("midreset_uo", int'(uo_out), 'h80);
    run(1000);
    chk("midreset_resettled", int'(uo_out), 'hC0);

    // Random stimulus: inputs held for random dwell times, sporadic hold/reset.
    for (int seg = 0; seg < 60; seg++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 80)); k++) begin
        ena   = ($urandom_range(0, 9) != 0);
        rst_n = ($urandom_range(0, 99) == 0);
        cyc();
        chk("rand_uio_oe", int'(uio_oe), 0);
      end
      rst_n = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
